// File: rtl/prog_loader.sv
// prog_loader: UART (8N1) boot loader writing a length-prefixed stream of 32-bit words into program memory.
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum byte is required before start_out.
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        rx,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  output logic        start_out,
  output logic        busy,
  output logic [8:0]  word_count,
  output logic        err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {IDLE, GET_LEN, GET_BYTE, WRITE, WRITE_HOLD, CHECK, DONE, ERR} st_t;
  rx_st_t rs, rs_n;
  st_t state, state_n;
  logic rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic tick, byte_valid, frame_err;
  logic pend, take, active;
  logic [7:0] pend_byte;
  logic [1:0] idx;
  logic [8:0] n_words, n_len;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else {rx_s1, rx_s2, rx_d} <= {rx, rx_s1, rx_s2};

  assign tick = cnt == (rs == R_START ? HALF : FULL);

  always_ff @(posedge clk or negedge rst)
    if (!rst) rs <= R_IDLE;
    else rs <= rs_n;

  always_comb begin
    rs_n = rs;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (rs)
      R_IDLE:  if (rx_d && !rx_s2) rs_n = R_START;
      R_START: if (tick) rs_n = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bit_idx == 3'd7) rs_n = R_STOP;
      default: if (tick) begin
        rs_n = R_IDLE;
        byte_valid = rx_s2;
        frame_err = !rx_s2;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      bit_idx <= 3'd0;
      sh <= 8'd0;
    end else begin
      cnt <= (tick || rs == R_IDLE) ? '0 : cnt + 1'b1;
      bit_idx <= rs != R_DATA ? 3'd0 : bit_idx + 3'(tick);
      if (rs == R_DATA && tick) sh <= {rx_s2, sh[7:1]};
    end

  assign active = state inside {GET_LEN, GET_BYTE, WRITE, WRITE_HOLD, CHECK};
  assign busy = state inside {GET_BYTE, WRITE, WRITE_HOLD, CHECK};
  assign mem_wren = state == WRITE;
  assign n_len = {1'b0, pend_byte} + 9'd1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    take = 1'b0;
    case (state)
      IDLE:       state_n = GET_LEN;
      GET_LEN:    if (pend) begin
        take = 1'b1;
        state_n = n_len > 9'(MAX_WORDS) ? ERR : GET_BYTE;
      end
      GET_BYTE:   if (pend) begin
        take = 1'b1;
        if (idx == 2'd3) state_n = WRITE;
      end
      WRITE:      state_n = WRITE_HOLD;
      WRITE_HOLD: state_n = word_count + 9'd1 == n_words ? CHECK : GET_BYTE;
`ifdef LOADER_CHECKSUM_EN
      CHECK:      if (pend) begin
        take = 1'b1;
        state_n = pend_byte == chk ? DONE : ERR;
      end
`else
      CHECK:      state_n = DONE;
`endif
      default:    ;
    endcase
    if (frame_err && active) state_n = ERR;
    if (!load_en) state_n = IDLE;
  end

  // A received byte waits in pend until a consuming state takes it, bridging the write cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend <= 1'b0;
      pend_byte <= 8'd0;
      n_words <= 9'd0;
      word_count <= 9'd0;
      idx <= 2'd0;
      mem_address <= 8'd0;
      mem_data <= 32'd0;
      start_out <= 1'b0;
      err <= 1'b0;
    end else begin
      if (!load_en || state inside {IDLE, DONE, ERR}) pend <= 1'b0;
      else if (byte_valid) pend <= 1'b1;
      else if (take) pend <= 1'b0;
      if (byte_valid) pend_byte <= sh;
      if (take && state == GET_LEN) begin
        n_words <= n_len;
        word_count <= 9'd0;
        idx <= 2'd0;
        mem_address <= 8'd0;
      end
      if (take && state == GET_BYTE) begin
        mem_data[{idx, 3'b000} +: 8] <= pend_byte;
        idx <= idx + 2'd1;
      end
      if (state == WRITE_HOLD) begin
        word_count <= word_count + 9'd1;
        mem_address <= mem_address + 8'd1;
      end
      start_out <= state_n == DONE && state != DONE;
      if (state_n == ERR && state != ERR) err <= 1'b1;
      else if (state_n == GET_LEN && state != GET_LEN) err <= 1'b0;
    end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) chk <= 8'd0;
    else if (take && state == GET_LEN) chk <= pend_byte;
    else if (take && state == GET_BYTE) chk <= chk ^ pend_byte;
`endif
endmodule
